// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
//   MM:SS stopwatch in packed BCD. It advances one step per divider tick,
//   counting up or down under start/stop/clear/load control.
//   Optional lap capture is enabled by defining STOPWATCH_LAP_EN.
// Parameters
//   MIN_MAX   packed-BCD upper minute value (8'h00..8'h99)
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   tick                 one-cycle count-enable pulse
//   start/stop/clear     run control (clear > load > stop > start > tick)
//   load, load_min/sec   packed-BCD preset; rejected presets pulse load_err
//   dir                  0 = up, 1 = down
//   min_bcd, sec_bcd     current count
//   running              high while in RUN
//   done                 one-cycle pulse at terminal count
//   load_err             one-cycle pulse on a rejected load
//   lap, lap_min/sec     lap capture (tied to 8'h00 unless STOPWATCH_LAP_EN)
module bcd_stopwatch #(
    parameter logic [7:0] MIN_MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       dir,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       load_err,
    input  logic       lap,
    output logic [7:0] lap_min,
    output logic [7:0] lap_sec
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] min_nx, sec_nx;
    logic       done_nx, err_nx;
    logic       load_bad;

    function automatic logic nib_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    // The highest active control consumes the cycle even when it has no effect
    // in the current state, so e.g. start while running still blocks the tick.
    always_comb begin
        state_nx = state;
        min_nx   = min_bcd;
        sec_nx   = sec_bcd;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        load_bad = !nib_ok(load_min) || !nib_ok(load_sec) ||
                   (load_sec > 8'h59) || (load_min > MIN_MAX);

        if (clear) begin
            state_nx = IDLE;
            min_nx   = '0;
            sec_nx   = '0;
        end else if (load) begin
            if (state != RUN) begin
                if (load_bad) begin
                    err_nx = 1'b1;
                end else begin
                    min_nx   = load_min;
                    sec_nx   = load_sec;
                    state_nx = IDLE;
                end
            end
        end else if (stop) begin
            if (state == RUN)
                state_nx = PAUSE;
        end else if (start) begin
            if ((state == IDLE || state == PAUSE) &&
                !(dir && min_bcd == 8'h00 && sec_bcd == 8'h00))
                state_nx = RUN;
        end else if (tick && state == RUN) begin
            if (!dir) begin
                if (sec_bcd == 8'h59) begin
                    sec_nx = '0;
                    if (min_bcd == MIN_MAX) begin
                        min_nx  = '0;
                        done_nx = 1'b1;
                    end else begin
                        min_nx = bcd_inc(min_bcd);
                    end
                end else begin
                    sec_nx = bcd_inc(sec_bcd);
                end
            end else begin
                // 00:00 is also treated as terminal so a mid-run direction
                // change at zero cannot underflow.
                if (min_bcd == 8'h00 && sec_bcd <= 8'h01) begin
                    min_nx   = '0;
                    sec_nx   = '0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else if (sec_bcd == 8'h00) begin
                    sec_nx = 8'h59;
                    min_nx = bcd_dec(min_bcd);
                end else begin
                    sec_nx = bcd_dec(sec_bcd);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            min_bcd  <= '0;
            sec_bcd  <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            min_bcd  <= min_nx;
            sec_bcd  <= sec_nx;
            running  <= (state_nx == RUN);
            done     <= done_nx;
            load_err <= err_nx;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Captures the registered (pre-tick) count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_min <= '0;
            lap_sec <= '0;
        end else if (clear) begin
            lap_min <= '0;
            lap_sec <= '0;
        end else if (lap) begin
            lap_min <= min_bcd;
            lap_sec <= sec_bcd;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_min    = '0;
    assign lap_sec    = '0;
`endif

    assert property (@(posedge clk) disable iff (rst)
        nib_ok(min_bcd) && nib_ok(sec_bcd) && (sec_bcd <= 8'h59));

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
//   Self-checking bench for bcd_stopwatch (MIN_MAX = 8'h59). Build with
//   +define+STOPWATCH_LAP_EN to exercise the lap capture.
module tb_bcd_stopwatch;

    logic       clk, rst, tick, start, stop, clear, load, dir, lap;
    logic [7:0] load_min, load_sec;
    logic [7:0] min_bcd, sec_bcd, lap_min, lap_sec;
    logic       running, done, load_err;

    bcd_stopwatch #(.MIN_MAX(8'h59)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_min(load_min), .load_sec(load_sec),
        .dir(dir), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
        .done(done), .load_err(load_err), .lap(lap), .lap_min(lap_min),
        .lap_sec(lap_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr, ld, stp, sta, tck, dr, lp;
        logic [7:0]  lmin, lsec;
        logic [34:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [34:0] exp;
    } sb_t;

    vec_t       tbl[$];
    sb_t        sbq[$];
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] lap_m = 8'h00;
    logic [7:0] lap_s = 8'h00;

    function automatic logic [7:0] bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic vec_t mk(input string n, input logic clr, input logic ld,
                                input logic stp, input logic sta, input logic tck,
                                input logic dr, input logic lp,
                                input logic [7:0] lmin, input logic [7:0] lsec,
                                input logic [7:0] emin, input logic [7:0] esec,
                                input logic erun, input logic edone, input logic eerr);
        vec_t v;
        v.name = n;
        v.clr = clr; v.ld = ld; v.stp = stp; v.sta = sta;
        v.tck = tck; v.dr = dr; v.lp = lp;
        v.lmin = lmin; v.lsec = lsec;
        v.exp = {emin, esec, erun, edone, eerr, lap_m, lap_s};
        return v;
    endfunction

    task automatic idle_inputs();
        clear = 0; load = 0; stop = 0; start = 0; tick = 0; dir = 0; lap = 0;
        load_min = 8'h00; load_sec = 8'h00;
    endtask

    task automatic check_out();
        sb_t         e;
        logic [34:0] got;
        got = {min_bcd, sec_bcd, running, done, load_err, lap_min, lap_sec};
        nvec++;
        if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL scoreboard_empty: got %h required an expectation", got);
        end else begin
            e = sbq.pop_front();
            if (got !== e.exp) begin
                nerr++;
                $display("FAIL %s: got %h:%h run=%b done=%b err=%b lap=%h:%h, required %h:%h run=%b done=%b err=%b lap=%h:%h",
                         e.name, got[34:27], got[26:19], got[18], got[17], got[16],
                         got[15:8], got[7:0], e.exp[34:27], e.exp[26:19], e.exp[18],
                         e.exp[17], e.exp[16], e.exp[15:8], e.exp[7:0]);
            end
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        clear = t.clr; load = t.ld; stop = t.stp; start = t.sta;
        tick = t.tck; dir = t.dr; lap = t.lp;
        load_min = t.lmin; load_sec = t.lsec;
        sbq.push_back('{t.name, t.exp});
        @(posedge clk);
        #1;
        check_out();
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              name            clr ld stp sta tck dr lp lmin   lsec   emin   esec   run dn err
        tbl.push_back(mk("start_tick",    0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h01, 1, 0, 0));
        tbl.push_back(mk("stop_tick",     0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h01, 0, 0, 0));
        tbl.push_back(mk("tick_pause",    0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h01, 0, 0, 0));
        tbl.push_back(mk("load_bad_sec",  0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'h01, 8'h01, 0, 0, 1));
        tbl.push_back(mk("err_clears",    0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h01, 0, 0, 0));
        tbl.push_back(mk("restart",       0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h01, 1, 0, 0));
        tbl.push_back(mk("load_in_run",   0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 8'h01, 8'h01, 1, 0, 0));
        tbl.push_back(mk("tick_down",     0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0));
        tbl.push_back(mk("borrow_sec",    0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 0, 0));
        tbl.push_back(mk("dir_up_carry",  0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0));
        tbl.push_back(mk("clear_load",    1, 1, 0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk("start_zero_dn", 0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk("load_bad_min",  0, 1, 0, 0, 0, 0, 0, 8'h60, 8'h00, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk("load_bad_mnib", 0, 1, 0, 0, 0, 0, 0, 8'h1A, 8'h00, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk("load_bad_snib", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h0F, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk("load_bad_s60",  0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h60, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk("load_1000",     0, 1, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 8'h00, 0, 0, 0));
        tbl.push_back(mk("stop_idle",     0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 8'h00, 0, 0, 0));
        tbl.push_back(mk("start_down",    0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h10, 8'h00, 1, 0, 0));
        tbl.push_back(mk("borrow_min",    0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h09, 8'h59, 1, 0, 0));
        tbl.push_back(mk("clear",         1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk("load_0003",     0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h03, 8'h00, 8'h03, 0, 0, 0));
        tbl.push_back(mk("start_0003",    0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0));
        tbl.push_back(mk("down_0002",     0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0));
        tbl.push_back(mk("down_0001",     0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0));
        tbl.push_back(mk("down_done",     0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        tbl.push_back(mk("done_drops",    0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk("start_in_done", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk("tick_in_done",  0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk("load_5959",     0, 1, 0, 0, 0, 0, 0, 8'h59, 8'h59, 8'h59, 8'h59, 0, 0, 0));
        tbl.push_back(mk("start_up",      0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h59, 8'h59, 1, 0, 0));
        tbl.push_back(mk("wrap_done",     0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk("after_wrap",    0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk("tick_post_wrap",0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0));

        rst = 1'b1;
        idle_inputs();
        #3;
        sbq.push_back('{"reset_state", 35'h0});
        check_out();
        @(negedge clk);
        rst = 1'b0;

        // Count up 61 seconds from 00:00.
        apply(mk("start", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        for (int k = 1; k <= 61; k++)
            apply(mk($sformatf("up_%0d", k), 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00,
                     bcd(k / 60), bcd(k % 60), 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Asynchronous reset between clock edges while running at 00:01.
        @(negedge clk);
        #2 rst = 1'b1;
        sbq.push_back('{"async_rst", 35'h0});
        #1 check_out();
        @(negedge clk);
        rst = 1'b0;
        apply(mk("tick_after_rst", 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));

`ifdef STOPWATCH_LAP_EN
        apply(mk("lap_start", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        for (int k = 1; k <= 10; k++)
            apply(mk($sformatf("lap_up_%0d", k), 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00,
                     8'h00, bcd(k), 1, 0, 0));
        lap_m = 8'h00; lap_s = 8'h10;
        apply(mk("lap_capture", 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0, 0));
        for (int k = 11; k <= 15; k++)
            apply(mk($sformatf("lap_up_%0d", k), 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00,
                     8'h00, bcd(k), 1, 0, 0));
        lap_s = 8'h15;
        apply(mk("lap_with_tick", 0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h16, 1, 0, 0));
        lap_s = 8'h00;
        apply(mk("lap_clear", 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
`else
        apply(mk("lap_start", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        apply(mk("lap_up", 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0));
        apply(mk("lap_ignored", 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
